vend_ctrl_param: RTL and testbench

Parametrised vending-machine controller, the successor of the fixed-price four-flip-flop vending machine. It accumulates credit from penny, ha'penny and farthing coins up to a configurable ceiling and vends at a configurable price. It then pays change one coin per cycle in ha'pennies and farthings, and supports cancel/refund and coin rejection. It sits between the debounced coin/clock/reset front end and the seven-segment/LED output logic.

---
 rtl/vend_ctrl_param.sv | 118 +++++++++++
 tb/tb_vend_ctrl_param.sv | 135 +++++++++++++
 2 files changed

// File: rtl/vend_ctrl_param.sv
// Parametrised vending-machine controller: accumulates coin credit up to a
// ceiling, vends at PRICE, then pays change one ha'penny/farthing per cycle.
module vend_ctrl_param #(
  parameter int unsigned PRICE      = 4,
  parameter int unsigned MAX_CREDIT = 15,
  parameter int unsigned CREDIT_W   = 5
) (
  input  logic                clk,
  input  logic                res,
  input  logic                coin_valid,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                vend,
  output logic                hap_ch,
  output logic                farth_ch,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_CHANGE
  } state_t;

  localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE     = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] TWO     = CREDIT_W'(2);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                rej_q, rej_d;

  logic [2:0]          coin_val;
  logic [CREDIT_W:0]   sum;
  logic                coin_ok;

  always_comb begin
    case (coin)
      2'b00:   coin_val = 3'd1;
      2'b01:   coin_val = 3'd2;
      2'b10:   coin_val = 3'd4;
      default: coin_val = 3'd0;
    endcase
  end

  // One extra bit so the ceiling compare cannot be fooled by wrap-around.
  assign sum     = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
  assign coin_ok = (coin != 2'b11) && (sum <= MAX_X);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    rej_d    = 1'b0;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (state_q == S_COLLECT && cancel) begin
          state_d = S_CHANGE;
          rej_d   = coin_valid;
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_d = sum[CREDIT_W-1:0];
            if (sum >= PRICE_X)
              state_d = S_VEND;
            else if (sum != '0)
              state_d = S_COLLECT;
            else
              state_d = S_IDLE;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      S_VEND: begin
        rej_d    = coin_valid;
        credit_d = credit_q - PRICE_C;
        state_d  = (credit_q != PRICE_C) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        rej_d = coin_valid;
        if (credit_q >= TWO)
          credit_d = credit_q - TWO;
        else
          credit_d = '0;
        if (credit_d == '0)
          state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      rej_q    <= rej_d;
    end
  end

  assign vend        = (state_q == S_VEND);
  assign hap_ch      = (state_q == S_CHANGE) && (credit_q >= TWO);
  assign farth_ch    = (state_q == S_CHANGE) && (credit_q == ONE);
  assign busy        = (state_q == S_VEND) || (state_q == S_CHANGE);
  assign coin_reject = rej_q;
  assign credit      = credit_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed vector bench for vend_ctrl_param: default-price instance driven
// from a table, plus a PRICE=15 instance exercising the credit ceiling.
module tb_vend_ctrl_param;

  logic       clk = 1'b0;
  logic       res;
  logic       coin_valid;
  logic [1:0] coin;
  logic       cancel;

  logic       a_vend, a_hap, a_farth, a_rej, a_busy;
  logic [4:0] a_credit;
  logic       b_vend, b_hap, b_farth, b_rej, b_busy;
  logic [4:0] b_credit;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  vend_ctrl_param #(.PRICE(4), .MAX_CREDIT(15), .CREDIT_W(5)) u_a (
    .clk(clk), .res(res), .coin_valid(coin_valid), .coin(coin), .cancel(cancel),
    .vend(a_vend), .hap_ch(a_hap), .farth_ch(a_farth), .coin_reject(a_rej),
    .busy(a_busy), .credit(a_credit)
  );

  vend_ctrl_param #(.PRICE(15), .MAX_CREDIT(15), .CREDIT_W(5)) u_b (
    .clk(clk), .res(res), .coin_valid(coin_valid), .coin(coin), .cancel(cancel),
    .vend(b_vend), .hap_ch(b_hap), .farth_ch(b_farth), .coin_reject(b_rej),
    .busy(b_busy), .credit(b_credit)
  );

  typedef struct {
    logic       res;
    logic       cv;
    logic [1:0] coin;
    logic       cancel;
    logic [9:0] exp; // {vend, hap, farth, rej, busy, credit[4:0]}
  } vec_t;

  vec_t vecs[$];

  localparam logic [1:0] FA = 2'b00, HA = 2'b01, PE = 2'b10, BAD = 2'b11;

  function automatic vec_t mk(input logic r, input logic cv, input logic [1:0] c,
                              input logic cn, input logic v, input logic h,
                              input logic f, input logic rj, input logic b,
                              input int unsigned cr);
    vec_t t;
    t.res = r; t.cv = cv; t.coin = c; t.cancel = cn;
    t.exp = {v, h, f, rj, b, 5'(cr)};
    return t;
  endfunction

  task automatic drive(input logic r, input logic cv, input logic [1:0] c, input logic cn);
    res = r; coin_valid = cv; coin = c; cancel = cn;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got v/h/f/rj/b=%b credit=%0d, expected v/h/f/rj/b=%b credit=%0d",
                  name, act[9:5], act[4:0], exp[9:5], exp[4:0]);
  endtask

  initial begin
    res = 1'b0; coin_valid = 1'b0; coin = FA; cancel = 1'b0;

    //            res cv coin can  v h f rj b cr
    vecs.push_back(mk(0, 0, FA, 0,  0,0,0,0,0, 0));  // reset
    vecs.push_back(mk(1, 0, FA, 1,  0,0,0,0,0, 0));  // cancel in IDLE ignored
    vecs.push_back(mk(1, 1, PE, 0,  1,0,0,0,1, 4));  // exact price -> vend
    vecs.push_back(mk(1, 0, FA, 0,  0,0,0,0,0, 0));  // no change
    vecs.push_back(mk(1, 1, HA, 0,  0,0,0,0,0, 2));
    vecs.push_back(mk(1, 1, FA, 0,  0,0,0,0,0, 3));
    vecs.push_back(mk(1, 1, PE, 0,  1,0,0,0,1, 7));
    vecs.push_back(mk(1, 0, FA, 0,  0,1,0,0,1, 3));  // ha'penny change
    vecs.push_back(mk(1, 0, FA, 0,  0,0,1,0,1, 1));  // farthing change
    vecs.push_back(mk(1, 0, FA, 0,  0,0,0,0,0, 0));
    vecs.push_back(mk(1, 1, FA, 0,  0,0,0,0,0, 1));  // three farthings
    vecs.push_back(mk(1, 1, FA, 0,  0,0,0,0,0, 2));
    vecs.push_back(mk(1, 1, FA, 0,  0,0,0,0,0, 3));
    vecs.push_back(mk(1, 0, FA, 1,  0,1,0,0,1, 3));  // cancel -> refund
    vecs.push_back(mk(1, 0, FA, 0,  0,0,1,0,1, 1));
    vecs.push_back(mk(1, 0, FA, 0,  0,0,0,0,0, 0));
    vecs.push_back(mk(1, 1, BAD,0,  0,0,0,1,0, 0));  // invalid coin in IDLE
    vecs.push_back(mk(1, 1, HA, 0,  0,0,0,0,0, 2));
    vecs.push_back(mk(1, 1, BAD,0,  0,0,0,1,0, 2));  // invalid coin at credit 2
    vecs.push_back(mk(1, 1, FA, 0,  0,0,0,0,0, 3));
    vecs.push_back(mk(1, 1, PE, 0,  1,0,0,0,1, 7));
    vecs.push_back(mk(1, 0, FA, 0,  0,1,0,0,1, 3));
    vecs.push_back(mk(1, 1, PE, 0,  0,0,1,1,1, 1));  // penny in CHANGE rejected
    vecs.push_back(mk(1, 0, FA, 0,  0,0,0,0,0, 0));
    vecs.push_back(mk(1, 1, HA, 0,  0,0,0,0,0, 2));
    vecs.push_back(mk(1, 1, PE, 1,  0,1,0,1,1, 2));  // cancel beats coin
    vecs.push_back(mk(1, 0, FA, 0,  0,0,0,0,0, 0));
    vecs.push_back(mk(1, 1, HA, 0,  0,0,0,0,0, 2));
    vecs.push_back(mk(1, 1, FA, 0,  0,0,0,0,0, 3));
    vecs.push_back(mk(1, 1, PE, 0,  1,0,0,0,1, 7));
    vecs.push_back(mk(1, 0, FA, 0,  0,1,0,0,1, 3));
    vecs.push_back(mk(0, 0, FA, 0,  0,0,0,0,0, 0));  // reset mid-CHANGE
    vecs.push_back(mk(1, 0, FA, 0,  0,0,0,0,0, 0));  // nothing pending

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].res, vecs[i].cv, vecs[i].coin, vecs[i].cancel);
      check($sformatf("a_vec%0d", i),
            {a_vend, a_hap, a_farth, a_rej, a_busy, a_credit}, vecs[i].exp);
    end

    // PRICE=15 instance: credit ceiling and exact-ceiling vend.
    drive(0, 0, FA, 0);
    check("b_reset", {b_vend, b_hap, b_farth, b_rej, b_busy, b_credit}, 10'b00000_00000);
    drive(1, 1, PE, 0);
    drive(1, 1, PE, 0);
    drive(1, 1, PE, 0);
    check("b_three_pennies", {b_vend, b_hap, b_farth, b_rej, b_busy, b_credit}, {5'b00000, 5'd12});
    drive(1, 1, PE, 0);
    check("b_over_ceiling", {b_vend, b_hap, b_farth, b_rej, b_busy, b_credit}, {5'b00010, 5'd12});
    drive(1, 1, HA, 0);
    check("b_hap_14", {b_vend, b_hap, b_farth, b_rej, b_busy, b_credit}, {5'b00000, 5'd14});
    drive(1, 1, FA, 0);
    check("b_vend_15", {b_vend, b_hap, b_farth, b_rej, b_busy, b_credit}, {5'b10001, 5'd15});
    drive(1, 0, FA, 0);
    check("b_idle_no_change", {b_vend, b_hap, b_farth, b_rej, b_busy, b_credit}, 10'b00000_00000);
    drive(1, 0, FA, 0);
    check("b_stays_idle", {b_vend, b_hap, b_farth, b_rej, b_busy, b_credit}, 10'b00000_00000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
